// File: rtl/ar_read_arbiter_pkg.sv
// Shared definitions for the two-master AR/R read arbiter: FSM states,
// AR bundle field offsets and the width helper for the widened-ID bundle.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    // Field offsets inside a master AR bundle; the ID sits above bit 48.
    localparam int AR_ID_LSB    = 49;
    localparam int AR_ADDR_MSB  = 48;
    localparam int AR_ADDR_LSB  = 17;
    localparam int AR_LEN_MSB   = 16;
    localparam int AR_LEN_LSB   = 13;
    localparam int AR_SIZE_MSB  = 12;
    localparam int AR_SIZE_LSB  = 11;
    localparam int AR_BURST_MSB = 10;
    localparam int AR_BURST_LSB = 9;
    localparam int AR_LOCK_MSB  = 8;
    localparam int AR_LOCK_LSB  = 7;
    localparam int AR_CACHE_MSB = 6;
    localparam int AR_CACHE_LSB = 3;
    localparam int AR_PROT_MSB  = 2;
    localparam int AR_PROT_LSB  = 0;

    function automatic int m_ar_width(input int tagbits);
        return AR_ID_LSB + tagbits;
    endfunction

    function automatic int s_ar_width(input int tagbits);
        return AR_ID_LSB + tagbits + 1;
    endfunction

endpackage

// File: rtl/ar_read_arbiter_outstanding_counter.sv
// Saturating per-master count of open read bursts; reports whether another
// burst may be issued without exceeding MaxOutstanding.
module outstanding_counter #(
    parameter int MaxOutstanding = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic below_limit_o
);

    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MaxOutstanding);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: simultaneous inc/dec cancel, decrement floors at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = (cnt_q == '0) ? '0 : (cnt_q - CW'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign below_limit_o = (cnt_q < LIMIT);

endmodule

// File: rtl/ar_read_arbiter.sv
// Two-master / one-slave read arbiter: round-robin AR grant with ID tagging,
// combinational R routing by RID MSB. Define ARB_FIXED_PRIORITY_EN for fixed M0 priority.
module ar_read_arbiter
    import arb_pkg::*;
#(
    parameter int BusWidth       = 32,
    parameter int tagbits        = 1,
    parameter int MaxOutstanding = 2
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic                              M0_ARVALID,
    output logic                              M0_ARREADY,
    input  logic [m_ar_width(tagbits)-1:0]    M0_AR,
    input  logic                              M1_ARVALID,
    output logic                              M1_ARREADY,
    input  logic [m_ar_width(tagbits)-1:0]    M1_AR,
    output logic                              S_ARVALID,
    input  logic                              S_ARREADY,
    output logic [s_ar_width(tagbits)-1:0]    S_AR,
    input  logic [tagbits:0]                  S_RID,
    input  logic [BusWidth-1:0]               S_RDATA,
    input  logic [1:0]                        S_RRESP,
    input  logic                              S_RLAST,
    input  logic                              S_RVALID,
    output logic                              S_RREADY,
    output logic [tagbits-1:0]                M0_RID,
    output logic [BusWidth-1:0]               M0_RDATA,
    output logic [1:0]                        M0_RRESP,
    output logic                              M0_RLAST,
    output logic                              M0_RVALID,
    input  logic                              M0_RREADY,
    output logic [tagbits-1:0]                M1_RID,
    output logic [BusWidth-1:0]               M1_RDATA,
    output logic [1:0]                        M1_RRESP,
    output logic                              M1_RLAST,
    output logic                              M1_RVALID,
    input  logic                              M1_RREADY
);

    localparam int MW = m_ar_width(tagbits);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       inc0_s, inc1_s, dec0_s, dec1_s;
    logic       room0_s, room1_s, elig0_s, elig1_s;
    logic       r_dst_s;
    logic [MW-1:0] ar_sel_s;

    outstanding_counter #(.MaxOutstanding(MaxOutstanding)) u_cnt0 (
        .clk_i(ACLK), .rst_ni(ARESETn), .inc_i(inc0_s), .dec_i(dec0_s), .below_limit_o(room0_s)
    );

    outstanding_counter #(.MaxOutstanding(MaxOutstanding)) u_cnt1 (
        .clk_i(ACLK), .rst_ni(ARESETn), .inc_i(inc1_s), .dec_i(dec1_s), .below_limit_o(room1_s)
    );

    assign elig0_s = M0_ARVALID && room0_s;
    assign elig1_s = M1_ARVALID && room1_s;

    // Grant FSM: pick a master in IDLE, hold the grant until the slave accepts.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        S_ARVALID    = 1'b0;
        M0_ARREADY   = 1'b0;
        M1_ARREADY   = 1'b0;
        inc0_s       = 1'b0;
        inc1_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig0_s && elig1_s) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    state_d = ST_GRANT0;
`else
                    state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
`endif
                end else if (elig0_s) begin
                    state_d = ST_GRANT0;
                end else if (elig1_s) begin
                    state_d = ST_GRANT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                S_ARVALID  = 1'b1;
                M0_ARREADY = S_ARREADY;
                if (S_ARREADY) begin
                    last_grant_d = 1'b0;
                    inc0_s       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_GRANT0;
                end
            end
            ST_GRANT1: begin
                S_ARVALID  = 1'b1;
                M1_ARREADY = S_ARREADY;
                if (S_ARREADY) begin
                    last_grant_d = 1'b1;
                    inc1_s       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_GRANT1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and round-robin pointer; last_grant resets to 1 so M0 wins the first tie.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Forwarded bundle: grant index prepended to the master's own ID.
    always_comb begin
        ar_sel_s = M0_AR;
        if (state_q == ST_GRANT1) begin
            ar_sel_s = M1_AR;
        end else begin
            ar_sel_s = M0_AR;
        end
    end

    assign S_AR = {(state_q == ST_GRANT1), ar_sel_s};

    assign r_dst_s   = S_RID[tagbits];
    assign S_RREADY  = r_dst_s ? M1_RREADY : M0_RREADY;
    assign M0_RVALID = S_RVALID && !r_dst_s;
    assign M1_RVALID = S_RVALID && r_dst_s;
    assign M0_RID    = S_RID[tagbits-1:0];
    assign M1_RID    = S_RID[tagbits-1:0];
    assign M0_RDATA  = S_RDATA;
    assign M1_RDATA  = S_RDATA;
    assign M0_RRESP  = S_RRESP;
    assign M1_RRESP  = S_RRESP;
    assign M0_RLAST  = S_RLAST;
    assign M1_RLAST  = S_RLAST;

    assign dec0_s = S_RVALID && S_RREADY && S_RLAST && !r_dst_s;
    assign dec1_s = S_RVALID && S_RREADY && S_RLAST && r_dst_s;

endmodule
